// File: rtl/mem_port_responder_pkg.sv
// Shared FSM state encoding and transfer-direction constants
// for the SRAM port responder.
package mem_port_responder_pkg;

  localparam int ST_W = 5;

  typedef logic [ST_W-1:0] state_t;

  localparam int IDLE_B   = 0;
  localparam int SETUP_B  = 1;
  localparam int ACCESS_B = 2;
  localparam int HOLD_B   = 3;
  localparam int DONE_B   = 4;

  localparam state_t ST_IDLE   = 5'b00001;
  localparam state_t ST_SETUP  = 5'b00010;
  localparam state_t ST_ACCESS = 5'b00100;
  localparam state_t ST_HOLD   = 5'b01000;
  localparam state_t ST_DONE   = 5'b10000;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

  function automatic logic is_write(input logic dir);
    return dir == DIR_WRITE;
  endfunction

endpackage

// File: rtl/mem_port_responder_wait_counter.sv
// 4-bit loadable down-counter timing the ACCESS phase.
// Saturates at zero; zero flag comes straight from the register.
module wait_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/mem_port_responder.sv
// Bus-to-SRAM responder: IDLE/SETUP/ACCESS/HOLD/DONE sequencer
// with every SRAM strobe taken straight from a flop.
module mem_port_responder
  import mem_port_responder_pkg::*;
#(
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W      = 16
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              MemReq,
  input  logic              MemDir,
  input  logic [ADDR_W-1:0] MemAddr,
  input  logic [7:0]        MEMDATA_in,
  output logic [7:0]        MEMDATA_out,
  output logic              MemAck,
  output logic              MemBusy,
  output logic [ADDR_W-1:0] SRAM_A,
  input  logic [7:0]        SRAM_DQ_in,
  output logic [7:0]        SRAM_DQ_out,
  output logic              SRAM_DQ_oe,
  output logic              SRAM_CE_n,
  output logic              SRAM_OE_n,
  output logic              SRAM_WE_n
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              dir_q, dir_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rdata_q, rdata_d;

  logic [ADDR_W-1:0] sram_a_q, sram_a_d;
  logic [7:0]        dq_out_q, dq_out_d;
  logic              dq_oe_q, dq_oe_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              ack_q, ack_d;

  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;

  wait_counter u_wait (
    .clk      (CLK),
    .rst_n    (RST_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (WS),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    dir_d    = dir_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (1'b1)
      state_q[IDLE_B]: begin
        if (MemReq) begin
          state_d = ST_SETUP;
          addr_d  = MemAddr;
          dir_d   = MemDir;
          wdata_d = MEMDATA_in;
        end
      end
      state_q[SETUP_B]: begin
        state_d  = ST_ACCESS;
        cnt_load = 1'b1;
      end
      state_q[ACCESS_B]: begin
        if (cnt_zero) begin
          state_d = ST_HOLD;
          if (!is_write(dir_q)) begin
            rdata_d = SRAM_DQ_in;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      state_q[HOLD_B]: begin
        state_d = ST_DONE;
      end
      state_q[DONE_B]: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobes are decoded from the next state so the flops
  // present them during the state they belong to.
  always_comb begin
    sram_a_d = sram_a_q;
    dq_out_d = dq_out_q;
    dq_oe_d  = dq_oe_q;
    ce_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    ack_d    = 1'b0;
    unique case (1'b1)
      state_d[SETUP_B]: begin
        ce_n_d   = 1'b0;
        sram_a_d = addr_d;
        dq_oe_d  = is_write(dir_d);
        if (is_write(dir_d)) begin
          dq_out_d = wdata_d;
        end
      end
      state_d[ACCESS_B]: begin
        ce_n_d = 1'b0;
        we_n_d = !is_write(dir_d);
        oe_n_d = is_write(dir_d);
      end
      state_d[HOLD_B]: begin
        ce_n_d = 1'b0;
      end
      state_d[DONE_B]: begin
        ack_d   = 1'b1;
        dq_oe_d = 1'b0;
      end
      default: begin
        dq_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      dir_q    <= DIR_READ;
      wdata_q  <= 8'h00;
      rdata_q  <= 8'h00;
      sram_a_q <= '0;
      dq_out_q <= 8'h00;
      dq_oe_q  <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      dir_q    <= dir_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      sram_a_q <= sram_a_d;
      dq_out_q <= dq_out_d;
      dq_oe_q  <= dq_oe_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      ack_q    <= ack_d;
    end
  end

  assign MEMDATA_out = rdata_q;
  assign MemAck      = ack_q;
  assign MemBusy     = !state_q[IDLE_B];
  assign SRAM_A      = sram_a_q;
  assign SRAM_DQ_out = dq_out_q;
  assign SRAM_DQ_oe  = dq_oe_q;
  assign SRAM_CE_n   = ce_n_q;
  assign SRAM_OE_n   = oe_n_q;
  assign SRAM_WE_n   = we_n_q;

endmodule

// File: tb/tb_mem_port_responder.sv
// Scoreboarded random bench for mem_port_responder with an
// SRAM model, plus a WAIT_STATES=0 instance for the short path.
module tb_mem_port_responder;
  import mem_port_responder_pkg::*;

  localparam int W = 2;

  typedef struct {
    int         ack_cyc;
    logic       dir;
    logic [7:0] data;
  } exp_t;

  logic CLK = 1'b0;
  logic RST_n = 1'b1;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic        MemReq, MemDir;
  logic [15:0] MemAddr;
  logic [7:0]  MEMDATA_in, MEMDATA_out;
  logic        MemAck, MemBusy;
  logic [15:0] SRAM_A;
  logic [7:0]  SRAM_DQ_in, SRAM_DQ_out;
  logic        SRAM_DQ_oe, SRAM_CE_n, SRAM_OE_n, SRAM_WE_n;

  mem_port_responder #(.WAIT_STATES(W), .ADDR_W(16)) dut (
    .CLK(CLK), .RST_n(RST_n),
    .MemReq(MemReq), .MemDir(MemDir), .MemAddr(MemAddr),
    .MEMDATA_in(MEMDATA_in), .MEMDATA_out(MEMDATA_out),
    .MemAck(MemAck), .MemBusy(MemBusy),
    .SRAM_A(SRAM_A), .SRAM_DQ_in(SRAM_DQ_in),
    .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_oe(SRAM_DQ_oe),
    .SRAM_CE_n(SRAM_CE_n), .SRAM_OE_n(SRAM_OE_n),
    .SRAM_WE_n(SRAM_WE_n)
  );

  logic        req0, dir0;
  logic [15:0] addr0;
  logic [7:0]  din0, dout0;
  logic        ack0, busy0;
  logic [15:0] a0;
  logic [7:0]  dqi0, dqo0;
  logic        dqoe0, ce_n0, oe_n0, we_n0;

  mem_port_responder #(.WAIT_STATES(0), .ADDR_W(16)) dut0 (
    .CLK(CLK), .RST_n(RST_n),
    .MemReq(req0), .MemDir(dir0), .MemAddr(addr0),
    .MEMDATA_in(din0), .MEMDATA_out(dout0),
    .MemAck(ack0), .MemBusy(busy0),
    .SRAM_A(a0), .SRAM_DQ_in(dqi0),
    .SRAM_DQ_out(dqo0), .SRAM_DQ_oe(dqoe0),
    .SRAM_CE_n(ce_n0), .SRAM_OE_n(oe_n0),
    .SRAM_WE_n(we_n0)
  );

  assign dqi0 = (!ce_n0 && !oe_n0) ? 8'h5A : 8'hEE;

  // 256-byte SRAM, aliased on the low address byte.
  function automatic logic [7:0] pat(input logic [7:0] a);
    return (a == 8'h34) ? 8'hA5 : (a ^ 8'h5A);
  endfunction

  logic [7:0] sram [0:255];
  logic       mem_ready = 1'b0;

  always @(posedge CLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) sram[i] <= pat(8'(i));
      mem_ready <= 1'b1;
    end else if (RST_n && !SRAM_CE_n && !SRAM_WE_n && SRAM_DQ_oe) begin
      sram[SRAM_A[7:0]] <= SRAM_DQ_out;
    end
  end

  assign SRAM_DQ_in = (!SRAM_CE_n && !SRAM_OE_n) ?
                      sram[SRAM_A[7:0]] : 8'hEE;

  // Reference model: flat byte array plus the last value read.
  logic [7:0] ref_mem [0:255];
  logic [7:0] last_read = 8'h00;
  exp_t       q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic d, input logic [15:0] a,
                                 input logic [7:0] wd, input int ack_at);
    exp_t e;
    e.ack_cyc = ack_at;
    e.dir     = d;
    if (d == DIR_WRITE) begin
      ref_mem[a[7:0]] = wd;
    end else begin
      last_read = ref_mem[a[7:0]];
    end
    e.data = last_read;
    return e;
  endfunction

  int we_cnt = 0, oe_cnt = 0, dqoe_cnt = 0;

  always @(negedge CLK) begin
    if (!RST_n) begin
      we_cnt = 0; oe_cnt = 0; dqoe_cnt = 0;
    end else begin
      if (!SRAM_WE_n) we_cnt++;
      if (!SRAM_OE_n) oe_cnt++;
      if (SRAM_DQ_oe) dqoe_cnt++;
      checks++;
      assert (SRAM_WE_n || SRAM_OE_n) else begin
        errors++;
        $display("FAIL strobe_overlap: WE_n=%b OE_n=%b", SRAM_WE_n, SRAM_OE_n);
      end
      if (q.size() > 0 && q[0].dir == DIR_READ) begin
        chk("dq_oe_in_read", int'(SRAM_DQ_oe), 0);
      end
      if (MemAck) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack at cycle %0d, required none", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("ack_cycle", cyc, e.ack_cyc);
          chk("memdata_out", int'(MEMDATA_out), int'(e.data));
          chk("we_low_cycles", we_cnt, e.dir ? W + 1 : 0);
          chk("oe_low_cycles", oe_cnt, e.dir ? 0 : W + 1);
          chk("dq_oe_cycles", dqoe_cnt, e.dir ? W + 3 : 0);
        end
        we_cnt = 0; oe_cnt = 0; dqoe_cnt = 0;
      end
    end
  end

  // Wait for IDLE at a falling edge; junk on the request inputs
  // while busy must be ignored by the DUT.
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge CLK);
    while (MemBusy && n < 100) begin
      MemReq     = 1'($urandom);
      MemDir     = 1'($urandom);
      MemAddr    = 16'($urandom);
      MEMDATA_in = 8'($urandom);
      n++;
      @(negedge CLK);
    end
    if (n >= 100) chk("idle_timeout", n, 0);
  endtask

  task automatic issue(input logic d, input logic [15:0] a,
                       input logic [7:0] wd);
    int r;
    wait_idle();
    MemReq = 1'b1; MemDir = d; MemAddr = a; MEMDATA_in = wd;
    r = cyc;
    @(posedge CLK);
    #1;
    MemReq = 1'b0;
    q.push_back(model(d, a, wd, r + W + 4));
  endtask

  task automatic burst3();
    logic       d [3];
    logic [15:0] a [3];
    logic [7:0] wd [3];
    int r0;
    d[0] = DIR_WRITE; a[0] = 16'h0011; wd[0] = 8'hC3;
    d[1] = DIR_READ;  a[1] = 16'h0011; wd[1] = 8'h00;
    d[2] = DIR_READ;  a[2] = 16'h0034; wd[2] = 8'h99;
    wait_idle();
    MemReq = 1'b1; MemDir = d[0]; MemAddr = a[0]; MEMDATA_in = wd[0];
    r0 = cyc;
    @(posedge CLK);
    #1;
    q.push_back(model(d[0], a[0], wd[0], r0 + W + 4));
    for (int k = 1; k < 3; k++) begin
      MemDir = d[k]; MemAddr = a[k]; MEMDATA_in = wd[k];
      q.push_back(model(d[k], a[k], wd[k], r0 + k * (W + 5) + W + 4));
      repeat (W + 5) @(posedge CLK);
      #1;
    end
    MemReq = 1'b0;
  endtask

  initial begin
    int r, ack_at, oe0, n;
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(8'(i));
    MemReq = 1'b0; MemDir = 1'b0; MemAddr = '0; MEMDATA_in = '0;
    req0 = 1'b0; dir0 = 1'b0; addr0 = '0; din0 = '0;
    #2 RST_n = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_ack", int'(MemAck), 0);
    chk("rst_busy", int'(MemBusy), 0);
    chk("rst_strobes", int'({SRAM_CE_n, SRAM_OE_n, SRAM_WE_n}), 7);
    chk("rst_dq_oe", int'(SRAM_DQ_oe), 0);
    chk("rst_memdata", int'(MEMDATA_out), 0);
    chk("rst_sram_a", int'(SRAM_A), 0);
    chk("rst_dq_out", int'(SRAM_DQ_out), 0);
    chk("rst_busy_w0", int'(busy0), 0);
    RST_n = 1'b1;

    issue(DIR_READ, 16'h1234, 8'h00);
    issue(DIR_WRITE, 16'h00FF, 8'h3C);
    issue(DIR_READ, 16'h00FF, 8'h00);
    wait_idle();
    chk("sram_model_ff", int'(sram[8'hFF]), 8'h3C);
    burst3();

    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom), 16'($urandom_range(0, 31)), 8'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge CLK);
    end

    // Abort a write in the middle of ACCESS.
    wait_idle();
    MemReq = 1'b1; MemDir = DIR_WRITE; MemAddr = 16'h80A0; MEMDATA_in = 8'h77;
    @(posedge CLK);
    #1;
    MemReq = 1'b0;
    n = 0;
    while (SRAM_WE_n && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("abort_reached_access", int'(SRAM_WE_n), 0);
    RST_n = 1'b0;
    #1;
    chk("abort_we_n", int'(SRAM_WE_n), 1);
    chk("abort_dq_oe", int'(SRAM_DQ_oe), 0);
    chk("abort_ce_n", int'(SRAM_CE_n), 1);
    chk("abort_ack", int'(MemAck), 0);
    chk("abort_memdata", int'(MEMDATA_out), 0);
    chk("abort_busy", int'(MemBusy), 0);
    last_read = 8'h00;
    repeat (2) @(negedge CLK);
    RST_n = 1'b1;
    issue(DIR_WRITE, 16'h0005, 8'h1E);
    issue(DIR_READ, 16'h1234, 8'h00);

    // Zero-wait-state instance: one ACCESS cycle, ack at cycle 4.
    @(negedge CLK);
    req0 = 1'b1; dir0 = DIR_READ; addr0 = 16'h0042;
    r = cyc;
    @(posedge CLK);
    #1;
    req0 = 1'b0;
    ack_at = -1;
    oe0 = 0;
    for (int i = 0; i < 20 && ack_at < 0; i++) begin
      @(negedge CLK);
      if (!oe_n0) oe0++;
      if (ack0) ack_at = cyc;
    end
    chk("w0_latency", ack_at - r, 4);
    chk("w0_oe_cycles", oe0, 1);
    chk("w0_data", int'(dout0), 8'h5A);

    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge CLK);
    chk("drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
